// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Contents: blank segment pattern, hex-to-segment table, digit index type,
// load FSM state enum and the registered display output payload.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SEG_W      = 7;

  // All segments off (active-low).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns, entry N is hex digit N.
  localparam logic [15:0][SEG_W-1:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } load_state_e;

  typedef struct packed {
    logic [SEG_W-1:0]      seg;
    logic [NUM_DIGITS-1:0] en;
  } disp_out_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake and display bus of the seven-segment scan controller.
// Signals: load_valid/load_ready/load_data (value handshake), blank_lz
// (leading-zero blanking request), sevent (segments, active-low),
// enable (digit anodes, active-low one-hot).
// master = value producer / display consumer, slave = scan controller.
interface seg7_scan_ctrl_if;

  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        blank_lz;
  logic [6:0]  sevent;
  logic [3:0]  enable;

  modport master (
    output load_valid,
    output load_data,
    output blank_lz,
    input  load_ready,
    input  sevent,
    input  enable
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  blank_lz,
    output load_ready,
    output sevent,
    output enable
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports: i_nibble (4-bit hex digit), o_seg_c (segments {g,f,e,d,c,b,a}).
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]       i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  assign o_seg_c = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller.
// Ports: clk, rst (synchronous, active-high), bus (slave side of
// seg7_scan_ctrl_if: load handshake in, registered sevent/enable out).
// New values are held pending and only committed at a frame boundary so a
// frame never mixes digits of two different values.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned PRESCALE = 100000,
  parameter bit          BLANK_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int unsigned PRESC_W = $clog2(PRESCALE);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] r_presc;
  digit_idx_t         r_digit;
  logic [DATA_W-1:0]  r_display;
  logic [DATA_W-1:0]  r_pending;
  load_state_e        r_state;
  load_state_e        w_next_state;
  logic               r_load_ready;
  logic               r_blank_lz;
  disp_out_t          r_out;

  logic               w_wrap;
  logic               w_slot_start;
  logic               w_frame_end;
  logic               w_capture;
  logic               w_commit;
  logic [3:0]         w_nibble;
  logic [SEG_W-1:0]   w_seg;
  logic [3:0]         w_zero_from;
  logic               w_blank_sel;
  logic               w_blank_digit;

  assign w_wrap       = (r_presc == PRESC_MAX);
  assign w_slot_start = (r_presc == '0);
  assign w_frame_end  = w_wrap && (r_digit == 2'd3);

  // Refresh prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_digit <= 2'd0;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_digit <= r_digit + 2'd1;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Load FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_valid) begin
          w_capture    = 1'b1;
          w_next_state = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_frame_end) begin
          w_commit     = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Load FSM state, pending and displayed values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_load_ready <= 1'b1;
      r_pending    <= '0;
      r_display    <= '0;
    end else begin
      r_state      <= w_next_state;
      r_load_ready <= (w_next_state == ST_IDLE);
      if (w_capture) r_pending <= bus.load_data;
      if (w_commit)  r_display <= r_pending;
    end
  end

  assign w_nibble = r_display[{r_digit, 2'b00} +: 4];

  seg7_hex_decoder u_hex_decoder (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg)
  );

  // w_zero_from[k]: nibble k and every higher nibble are zero.
  always_comb begin
    w_zero_from    = 4'b0000;
    w_zero_from[3] = (r_display[15:12] == 4'h0);
    w_zero_from[2] = w_zero_from[3] && (r_display[11:8] == 4'h0);
    w_zero_from[1] = w_zero_from[2] && (r_display[7:4] == 4'h0);
    w_zero_from[0] = 1'b0;
  end

  // blank_lz is taken live on a slot's first cycle and held for the rest of it.
  assign w_blank_sel   = BLANK_EN && (w_slot_start ? bus.blank_lz : r_blank_lz);
  assign w_blank_digit = w_blank_sel && w_zero_from[r_digit];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank_lz <= 1'b0;
    end else if (w_slot_start) begin
      r_blank_lz <= bus.blank_lz;
    end
  end

  // One-cycle output pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out.seg <= SEG_BLANK;
      r_out.en  <= 4'hF;
    end else if (w_blank_digit) begin
      r_out.seg <= SEG_BLANK;
      r_out.en  <= 4'hF;
    end else begin
      r_out.seg <= w_seg;
      r_out.en  <= ~(4'b0001 << r_digit);
    end
  end

  assign bus.load_ready = r_load_ready;
  assign bus.sevent     = r_out.seg;
  assign bus.enable     = r_out.en;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Drives the board's 4-digit multiplexed seven-segment display from a 16-bit value produced by DataPath.
- Time-multiplexes the shared segment bus across the four digits using a refresh prescaler.
- Accepts new display values through a valid/ready handshake.
- Applies new values only at frame boundaries, so the display never shows a torn mix of old and new digits.

Parameters:
- PRESCALE, 100000, clock cycles each digit stays lit (1 ms at 100 MHz); legal minimum 2.
- BLANK_EN, 1, 1 = leading-zero blanking hardware is present; 0 = blank_lz input is ignored.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous and active-high
- load_valid  input  1  load_data is valid this cycle
- load_ready  output  1  block can accept a new value
- load_data  input  16  value to display; 4 hex nibbles, nibble 0 is the LSB
- blank_lz  input  1  blank leading zero digits
- sevent  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
- enable  output  4  digit anodes, active-low one-hot, enable[0] = nibble 0, registered

Behaviour:
- Reset (rst high at a clk edge):
  - prescale counter = 0, digit index = 0, display_reg = 16'h0000, pending flag = 0.
  - sevent = 7'h7F, enable = 4'hF, load_ready = 1.
  - Any pending value is discarded, including one caught mid-handshake.
- Prescaler: counts 0..PRESCALE-1 and wraps. When it wraps, digit index advances 0→1→2→3→0.
- Frame boundary: the cycle where prescale == PRESCALE-1 and digit index == 3.
- Load FSM, two states:
  - IDLE: load_ready = 1. If load_valid, capture load_data into pending_reg and move to PEND.
  - PEND: load_ready = 0. On a frame boundary, copy pending_reg to display_reg and move to IDLE. load_ready is high again the next cycle.
  - A value accepted on a frame-boundary cycle does not commit on that boundary. It commits on the following boundary.
  - load_valid while load_ready = 0 is not accepted. The producer must hold load_data until it sees load_ready.
  - Worst-case accept-to-commit latency = 4*PRESCALE cycles.
- Output pipeline, one cycle: each clk edge registers sevent and enable from the current digit index and display_reg.
  - First lit digit after reset release: digit 0, displaying 0 (sevent = 7'h40, enable = 4'b1110) one cycle after rst falls.
- Hex encoding, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking (blank_lz = 1 and BLANK_EN = 1):
  - Digit k (k = 3..1) is blanked when nibble k and all higher nibbles are zero.
  - Digit 0 is never blanked.
  - A blanked slot outputs enable = 4'hF and sevent = 7'h7F, and still occupies its full PRESCALE time.
  - blank_lz is sampled every cycle; a change takes effect on the next digit slot.
- A commit always lands at the start of digit 0, so each frame shows exactly one value.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK = 7'h7F constant.
  - 16-entry hex-to-segment constant table.
  - Digit-index type, 2 bits.
  - Load FSM state enum {IDLE, PEND}.
- Sub-module seg7_hex_decoder: purely combinational, 4-bit nibble in, 7-bit active-low segments out. It is the natural split and is reused by other display paths.
- Top level holds prescaler, digit counter, load FSM, blanking logic and output registers.

Test Plan (PRESCALE = 4):
- Reset and hold:
  - rst high for 2 cycles → sevent = 7F, enable = F, load_ready = 1.
  - Release rst → next cycle sevent = 40, enable = 1110. enable then steps to 1101, 1011, 0111, each for 4 cycles; all digits show 40.
- Load and no-tear:
  - Pulse load_valid with 16'h1234 mid-frame → load_ready = 0 the next cycle.
  - Digits keep showing 0 until the boundary. The next frame shows 19, 30, 24, 79 on enable 1110, 1101, 1011, 0111.
  - load_ready = 1 the cycle after the boundary.
- Back-pressure: while in PEND, hold load_valid high with 16'hABCD → not accepted until load_ready returns. 1234 is displayed for at least one full frame before ABCD appears.
- Boundary-cycle accept: assert load_valid only on the frame-boundary cycle with 16'h00FF → the value commits one full frame (16 cycles) later, not immediately.
- Blanking:
  - Display 16'h0005 with blank_lz = 1 → slot 0 shows sevent 12 on enable 1110; slots 1–3 show enable F and sevent 7F.
  - 16'h0500 → digits 0 and 1 show 40; digit 3 is blank.
- Reset mid-operation: assert rst while in PEND with 16'hBEEF pending → after release the display shows 0000, BEEF never appears, and load_ready = 1.
